// File: rtl/pulse_ext_pkg.sv
// Shared types and helpers for the multi-channel pulse extender.
// Define PULSE_EXT_RETRIG_EN to let a trigger during a pulse restart it instead of flagging a drop.
package pulse_ext_pkg;

  localparam int PE_CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } pe_state_e;

  typedef logic [PE_CNT_W-1:0] len_t;
  typedef logic [PE_CNT_W-1:0] cnt_t;

  // A programmed length of zero still produces a one-cycle pulse.
  function automatic int unsigned pe_leff(input int unsigned len);
    return (len == 0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/pulse_ext_channel.sv
// One pulse-extender channel: edge detect, length register, IDLE/PULSE FSM and down-counter.
// Honours PULSE_EXT_RETRIG_EN (retrigger extends the pulse) when defined.
module pulse_ext_channel #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_LEN = 2
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_x,
  input  logic             i_cfg_we,
  input  logic [CNT_W-1:0] i_cfg_len,
  output logic             o_x,
  output logic             o_drop
);
  import pulse_ext_pkg::*;

  pe_state_e        r_state;
  pe_state_e        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] w_leff_m1;
  logic             r_x_q;
  logic             w_trig;

  assign w_trig    = i_x & ~r_x_q;
  // Length is taken from the register as it stands before any same-cycle write lands.
  assign w_leff_m1 = CNT_W'(pe_leff(32'(r_len)) - 32'd1);

`ifdef PULSE_EXT_RETRIG_EN
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_state_next = PULSE;
          w_cnt_next   = w_leff_m1;
        end
      end
      PULSE: begin
        if (w_trig) begin
          w_cnt_next = w_leff_m1;
        end else if (r_cnt == '0) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_drop = 1'b0;
`else
  logic r_drop;
  logic w_drop_next;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_drop_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_state_next = PULSE;
          w_cnt_next   = w_leff_m1;
        end
      end
      PULSE: begin
        // Busy channel: a new edge is discarded, including one in the last pulse cycle.
        w_drop_next = w_trig;
        if (r_cnt == '0) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_drop_next;
    end
  end

  assign o_drop = r_drop;
`endif

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x_q   <= 1'b0;
      r_len   <= CNT_W'(DEFAULT_LEN);
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_x_q   <= i_x;
      if (i_cfg_we) begin
        r_len <= i_cfg_len;
      end
    end
  end

  assign o_x = (r_state == PULSE);

endmodule

// File: rtl/multi_pulse_extender.sv
// N-channel rising-edge pulse extender with per-channel runtime length registers.
// Build option PULSE_EXT_RETRIG_EN: retriggering a busy channel extends its pulse.
module multi_pulse_extender #(
  parameter  int N_CH        = 4,
  parameter  int CNT_W       = 8,
  parameter  int DEFAULT_LEN = 2,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [N_CH-1:0]  i_x,
  input  logic             i_cfg_we,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [CNT_W-1:0] i_cfg_len,
  output logic [N_CH-1:0]  o_x,
  output logic [N_CH-1:0]  o_drop,
  output logic             o_busy
);

  logic [N_CH-1:0] w_cfg_we;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      // Indices at or above N_CH never match, so such writes fall on the floor.
      assign w_cfg_we[gi] = i_cfg_we && (i_cfg_ch == CH_W'(gi));

      pulse_ext_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_LEN (DEFAULT_LEN)
      ) u_channel (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_x       (i_x[gi]),
        .i_cfg_we  (w_cfg_we[gi]),
        .i_cfg_len (i_cfg_len),
        .o_x       (o_x[gi]),
        .o_drop    (o_drop[gi])
      );
    end
  endgenerate

  assign o_busy = |o_x;

endmodule
